// File: rtl/conway_cell_seq.sv
// conway_cell_seq
// One Game-of-Life cell. The eight neighbour states are read over four
// cycles through two external 4:1 muxes (neighbours 0-3 on mux_lo,
// neighbours 4-7 on mux_hi) that share this cell's select output. The
// live total is accumulated, and then the B3/S23 rule is applied to the
// cell's own state register.
//
// Sequence for one generation (enabled edges only):
//   E0     step taken in IDLE            -> COUNT, idx=0
//   E1..E4 sample with select 0..3       -> acc += lo + hi
//   E5     APPLY                         -> alive, neighbor_count, done
// alive changes only at E5. Every cell that shares a step therefore
// samples the old generation for the whole count.
module conway_cell_seq #(
   parameter logic INIT_STATE = 1'b0
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       ena,
   input  logic       step,
   input  logic       load,
   input  logic       load_value,
   input  logic       mux_lo,
   input  logic       mux_hi,
   output logic [1:0] mux_select,
   output logic       alive,
   output logic [3:0] neighbor_count,
   output logic       busy,
   output logic       done
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_COUNT = 2'd1,
      S_APPLY = 2'd2
   } state_t;

   state_t     r_state;
   state_t     w_next;
   logic [1:0] r_idx;
   logic [3:0] r_acc;
   logic       r_alive;
   logic [3:0] r_ncount;
   logic       r_done;

   logic [3:0] w_sum;
   logic       w_rule;
   logic       w_last;

   // At most 8 live neighbours, so a 4-bit accumulator cannot overflow.
   assign w_sum  = r_acc + {3'b000, mux_lo} + {3'b000, mux_hi};
   // B3/S23: birth on exactly 3, survival on 2 or 3.
   assign w_rule = (r_acc == 4'd3) | (r_alive & (r_acc == 4'd2));
   assign w_last = (r_idx == 2'd3);

   // FSM state register; ena low freezes the sequence where it stands
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         r_state <= S_IDLE;
      else if (ena)
         r_state <= w_next;
   end

   // Next-state logic: load always returns to IDLE (abort when busy)
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  if (!load && step) w_next = S_COUNT;
         S_COUNT: begin
            if (load)        w_next = S_IDLE;
            else if (w_last) w_next = S_APPLY;
         end
         S_APPLY: w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   // Output decode from the state register
   always_comb begin
      busy = (r_state == S_COUNT) || (r_state == S_APPLY);
   end

   // Select index and accumulator. The index wraps from 3 to 0 on the
   // last sample, so the select is already 0 during APPLY.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_idx <= 2'd0;
         r_acc <= 4'd0;
      end else if (ena) begin
         case (r_state)
            S_IDLE: begin
               if (!load && step) begin
                  r_idx <= 2'd0;
                  r_acc <= 4'd0;
               end
            end
            S_COUNT: begin
               if (load) begin
                  r_idx <= 2'd0;
                  r_acc <= 4'd0;
               end else begin
                  r_idx <= r_idx + 2'd1;
                  r_acc <= w_sum;
               end
            end
            S_APPLY: begin
               if (load) begin
                  r_idx <= 2'd0;
                  r_acc <= 4'd0;
               end
            end
            default: begin
               r_idx <= 2'd0;
               r_acc <= 4'd0;
            end
         endcase
      end
   end

   // Cell state. A load is taken in any state and overrides the rule.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         r_alive <= INIT_STATE;
      else if (ena) begin
         if (load)
            r_alive <= load_value;
         else if (r_state == S_APPLY)
            r_alive <= w_rule;
      end
   end

   // Published count and the done pulse. An aborted APPLY publishes
   // nothing and raises no done.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ncount <= 4'd0;
         r_done   <= 1'b0;
      end else if (ena) begin
         r_done <= 1'b0;
         if (r_state == S_APPLY && !load) begin
            r_ncount <= r_acc;
            r_done   <= 1'b1;
         end
      end
   end

   assign mux_select     = r_idx;
   assign alive          = r_alive;
   assign neighbor_count = r_ncount;
   assign done           = r_done;

endmodule

// File: tb/tb_conway_cell_seq.sv
// Directed bench for conway_cell_seq (INIT_STATE=1). The neighbour mux
// pair is modelled as two 4-entry tables indexed by the DUT's select.
module tb_conway_cell_seq;

   logic       clk = 1'b0;
   logic       rst_n, ena, step, load, load_value;
   logic       mux_lo, mux_hi;
   logic [1:0] mux_select;
   logic       alive, busy, done;
   logic [3:0] neighbor_count;
   logic [3:0] lo_pat, hi_pat;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   assign mux_lo = lo_pat[mux_select];
   assign mux_hi = hi_pat[mux_select];

   conway_cell_seq #(.INIT_STATE(1'b1)) dut (
      .clk(clk), .rst_n(rst_n), .ena(ena), .step(step), .load(load),
      .load_value(load_value), .mux_lo(mux_lo), .mux_hi(mux_hi),
      .mux_select(mux_select), .alive(alive),
      .neighbor_count(neighbor_count), .busy(busy), .done(done)
   );

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic load_alive(input logic v);
      load = 1'b1; load_value = v;
      tick();
      load = 1'b0;
      checks++;
      if (alive !== v) begin errors++; $display("FAIL load_alive: got %0b exp %0b", alive, v); end
   endtask

   // One full generation with select stepping and result checks.
   task automatic run_gen(input string nm, input logic [3:0] lo, input logic [3:0] hi,
                          input logic [3:0] exp_nc, input logic exp_alive);
      lo_pat = lo; hi_pat = hi;
      step = 1'b1;
      tick();
      step = 1'b0;
      checks++;
      if (busy !== 1'b1 || mux_select !== 2'd0) begin
         errors++; $display("FAIL %s_e0: busy %0b sel %0d exp 1 0", nm, busy, mux_select);
      end
      for (int k = 1; k < 4; k++) begin
         tick();
         checks++;
         if (mux_select !== 2'(k)) begin
            errors++; $display("FAIL %s_sel: got %0d exp %0d", nm, mux_select, k);
         end
      end
      tick();
      checks++;
      if (mux_select !== 2'd0 || busy !== 1'b1 || done !== 1'b0) begin
         errors++; $display("FAIL %s_e4: sel %0d busy %0b done %0b exp 0 1 0", nm, mux_select, busy, done);
      end
      tick();
      checks++;
      if (neighbor_count !== exp_nc) begin
         errors++; $display("FAIL %s_count: got %0d exp %0d", nm, neighbor_count, exp_nc);
      end
      checks++;
      if (alive !== exp_alive || done !== 1'b1 || busy !== 1'b0) begin
         errors++; $display("FAIL %s_e5: alive %0b done %0b busy %0b exp %0b 1 0", nm, alive, done, busy, exp_alive);
      end
      tick();
      checks++;
      if (done !== 1'b0) begin errors++; $display("FAIL %s_done_pulse: got %0b exp 0", nm, done); end
   endtask

   task automatic test_reset;
      rst_n = 1'b0; ena = 1'b1; step = 1'b0; load = 1'b0; load_value = 1'b0;
      lo_pat = 4'h0; hi_pat = 4'h0;
      tick();
      checks++;
      if (alive !== 1'b1 || mux_select !== 2'd0 || busy !== 1'b0 || done !== 1'b0 || neighbor_count !== 4'd0) begin
         errors++;
         $display("FAIL reset: alive %0b sel %0d busy %0b done %0b nc %0d exp 1 0 0 0 0", alive, mux_select, busy, done, neighbor_count);
      end
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_birth;
      load_alive(1'b0);
      run_gen("birth", 4'b0101, 4'b1000, 4'd3, 1'b1);
   endtask

   task automatic test_survival_death;
      run_gen("survive2", 4'b0011, 4'b0000, 4'd2, 1'b1);
      run_gen("die4", 4'b1111, 4'b0000, 4'd4, 1'b0);
      run_gen("dead2", 4'b0000, 4'b0110, 4'd2, 1'b0);
      load_alive(1'b1);
      run_gen("all8", 4'b1111, 4'b1111, 4'd8, 1'b0);
   endtask

   task automatic test_abort;
      lo_pat = 4'b1111; hi_pat = 4'b1111;
      step = 1'b1;
      tick();              // E0
      step = 1'b0;
      tick();              // E1
      load = 1'b1; load_value = 1'b1;
      tick();              // E2: abort
      load = 1'b0;
      checks++;
      if (busy !== 1'b0 || alive !== 1'b1 || mux_select !== 2'd0 || done !== 1'b0 || neighbor_count !== 4'd8) begin
         errors++;
         $display("FAIL abort: busy %0b alive %0b sel %0d done %0b nc %0d exp 0 1 0 0 8", busy, alive, mux_select, done, neighbor_count);
      end
      tick(); tick(); tick();
      checks++;
      if (busy !== 1'b0 || done !== 1'b0 || neighbor_count !== 4'd8) begin
         errors++; $display("FAIL abort_after: busy %0b done %0b nc %0d exp 0 0 8", busy, done, neighbor_count);
      end
   endtask

   task automatic test_load_step;
      load = 1'b1; load_value = 1'b0; step = 1'b1;
      tick();
      load = 1'b0; step = 1'b0;
      checks++;
      if (alive !== 1'b0 || busy !== 1'b0) begin
         errors++; $display("FAIL load_step: alive %0b busy %0b exp 0 0", alive, busy);
      end
   endtask

   task automatic test_stall;
      lo_pat = 4'b0101; hi_pat = 4'b1000;
      step = 1'b1;
      tick();              // E0
      step = 1'b0;
      tick(); tick();      // E1, E2 -> select 2
      ena = 1'b0; step = 1'b1;
      tick(); tick(); tick();
      checks++;
      if (mux_select !== 2'd2 || busy !== 1'b1 || alive !== 1'b0) begin
         errors++; $display("FAIL stall_hold: sel %0d busy %0b alive %0b exp 2 1 0", mux_select, busy, alive);
      end
      ena = 1'b1;          // step still high: must be ignored while busy
      tick();              // E3
      step = 1'b0;
      checks++;
      if (mux_select !== 2'd3) begin errors++; $display("FAIL stall_resume: sel %0d exp 3", mux_select); end
      tick();              // E4
      tick();              // E5
      checks++;
      if (neighbor_count !== 4'd3 || alive !== 1'b1 || done !== 1'b1) begin
         errors++; $display("FAIL stall_result: nc %0d alive %0b done %0b exp 3 1 1", neighbor_count, alive, done);
      end
      ena = 1'b0;
      tick();
      checks++;
      if (done !== 1'b1) begin errors++; $display("FAIL stall_done_hold: got %0b exp 1", done); end
      ena = 1'b1;
      tick();
      checks++;
      if (done !== 1'b0 || busy !== 1'b0) begin
         errors++; $display("FAIL stall_no_requeue: done %0b busy %0b exp 0 0", done, busy);
      end
      tick(); tick(); tick(); tick(); tick(); tick();
      checks++;
      if (busy !== 1'b0 || done !== 1'b0 || alive !== 1'b1) begin
         errors++; $display("FAIL stall_idle: busy %0b done %0b alive %0b exp 0 0 1", busy, done, alive);
      end
   endtask

   task automatic test_reset_midcount;
      load_alive(1'b0);
      lo_pat = 4'b1111; hi_pat = 4'b1111;
      step = 1'b1;
      tick();
      step = 1'b0;
      tick();              // mid-COUNT, select 1
      rst_n = 1'b0;
      #1;
      checks++;
      if (alive !== 1'b1 || mux_select !== 2'd0 || busy !== 1'b0 || done !== 1'b0 || neighbor_count !== 4'd0) begin
         errors++;
         $display("FAIL reset_mid: alive %0b sel %0d busy %0b done %0b nc %0d exp 1 0 0 0 0", alive, mux_select, busy, done, neighbor_count);
      end
      tick();
      rst_n = 1'b1;
      tick();
      checks++;
      if (busy !== 1'b0 || mux_select !== 2'd0) begin
         errors++; $display("FAIL reset_release: busy %0b sel %0d exp 0 0", busy, mux_select);
      end
   endtask

   initial begin
      test_reset();
      test_birth();
      test_survival_death();
      test_abort();
      test_load_step();
      test_stall();
      test_reset_midcount();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
